// File: rtl/otter_prog_pkg.sv
// Shared types and constants for the OTTER UART program loader.
package otter_prog_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      COUNT,
      DATA,
      DONE
   } ld_state_t;

   localparam logic [7:0] MAGIC     = 8'h5A;
   localparam int         FIELD_LEN = 4;
   localparam logic [1:0] LAST_IDX  = 2'(FIELD_LEN - 1);

endpackage

// File: rtl/otter_prog_loader_if.sv
// Program-memory write port plus core-control/status lines driven by the loader.
interface otter_prog_loader_if;
   logic        prog_we;
   logic [31:0] prog_addr;
   logic [31:0] prog_data;
   logic        cpu_rst;
   logic        busy;
   logic        err;

   modport master (output prog_we, prog_addr, prog_data, cpu_rst, busy, err);
   modport slave  (input  prog_we, prog_addr, prog_data, cpu_rst, busy, err);
endinterface

// File: rtl/otter_prog_loader_uart_rx.sv
// 8N1 UART receiver: synchronised RX, half-bit start validation, centre sampling,
// one-cycle valid or frame_err pulse after the stop-bit sample.
module uart_rx #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       valid,
   output logic       frame_err
);
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;

   localparam int            CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

   rx_state_t     state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [2:0]    bit_reg, bit_next;
   logic [7:0]    sh_reg, sh_next;
   logic          valid_reg, valid_next;
   logic          ferr_reg, ferr_next;
   logic          sync1_reg, sync2_reg, prev_reg;
   logic          fall;

   assign fall      = prev_reg & ~sync2_reg;
   assign rx_byte   = sh_reg;
   assign valid     = valid_reg;
   assign frame_err = ferr_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg <= 1'b1;
         sync2_reg <= 1'b1;
         prev_reg  <= 1'b1;
         state_reg <= RX_IDLE;
         cnt_reg   <= '0;
         bit_reg   <= '0;
         sh_reg    <= '0;
         valid_reg <= 1'b0;
         ferr_reg  <= 1'b0;
      end else begin
         sync1_reg <= rx;
         sync2_reg <= sync1_reg;
         prev_reg  <= sync2_reg;
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         bit_reg   <= bit_next;
         sh_reg    <= sh_next;
         valid_reg <= valid_next;
         ferr_reg  <= ferr_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      bit_next   = bit_reg;
      sh_next    = sh_reg;
      valid_next = 1'b0;
      ferr_next  = 1'b0;
      case (state_reg)
         RX_IDLE: begin
            cnt_next = '0;
            if (fall) state_next = RX_START;
         end
         RX_START: begin
            // A start bit that is high again at half-bit was a glitch.
            if (cnt_reg == HALF) begin
               cnt_next   = '0;
               bit_next   = '0;
               state_next = sync2_reg ? RX_IDLE : RX_BITS;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         RX_BITS: begin
            if (cnt_reg == FULL) begin
               cnt_next = '0;
               sh_next  = {sync2_reg, sh_reg[7:1]};
               bit_next = bit_reg + 3'd1;
               if (bit_reg == 3'd7) state_next = RX_STOP;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         RX_STOP: begin
            if (cnt_reg == FULL) begin
               state_next = RX_IDLE;
               valid_next = sync2_reg;
               ferr_next  = ~sync2_reg;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: state_next = RX_IDLE;
      endcase
   end

endmodule

// File: rtl/otter_prog_loader.sv
// Receives a magic/address/count/data frame over UART and streams it as word
// writes into OTTER program memory while holding the core in reset.
module otter_prog_loader
   import otter_prog_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int TIMEOUT_CYC  = 10_000_000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                rx,
   otter_prog_loader_if.master prog
);
   logic [7:0]  rx_byte;
   logic        rx_valid, rx_ferr;

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .rx_byte   (rx_byte),
      .valid     (rx_valid),
      .frame_err (rx_ferr)
   );

   ld_state_t   state_reg, state_next;
   logic [1:0]  idx_reg, idx_next;
   logic [23:0] field_reg, field_next;
   logic [31:0] addr_reg, addr_next;
   logic [31:0] cnt_reg, cnt_next;
   logic [31:0] tmo_reg, tmo_next;
   logic        we_reg, we_next;
   logic [31:0] paddr_reg, paddr_next;
   logic [31:0] pdata_reg, pdata_next;
   logic        err_reg, err_next;
   logic        cpu_rst_reg, first_reg;
   logic [31:0] field_full;
   logic        tmo_hit;

   // Fields arrive LSB first, so the newest byte lands on top.
   assign field_full = {rx_byte, field_reg};
   assign tmo_hit    = (tmo_reg == 32'(TIMEOUT_CYC - 1)) && !rx_valid;

   assign prog.prog_we   = we_reg;
   assign prog.prog_addr = paddr_reg;
   assign prog.prog_data = pdata_reg;
   assign prog.cpu_rst   = cpu_rst_reg;
   assign prog.busy      = (state_reg != IDLE);
   assign prog.err       = err_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         idx_reg     <= '0;
         field_reg   <= '0;
         addr_reg    <= '0;
         cnt_reg     <= '0;
         tmo_reg     <= '0;
         we_reg      <= 1'b0;
         paddr_reg   <= '0;
         pdata_reg   <= '0;
         err_reg     <= 1'b0;
         cpu_rst_reg <= 1'b1;
         first_reg   <= 1'b1;
      end else begin
         state_reg   <= state_next;
         idx_reg     <= idx_next;
         field_reg   <= field_next;
         addr_reg    <= addr_next;
         cnt_reg     <= cnt_next;
         tmo_reg     <= tmo_next;
         we_reg      <= we_next;
         paddr_reg   <= paddr_next;
         pdata_reg   <= pdata_next;
         err_reg     <= err_next;
         // Core stays held for one full cycle after reset release or after returning to IDLE.
         cpu_rst_reg <= (state_reg != IDLE) || first_reg;
         first_reg   <= 1'b0;
      end
   end

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      field_next = field_reg;
      addr_next  = addr_reg;
      cnt_next   = cnt_reg;
      tmo_next   = '0;
      we_next    = 1'b0;
      paddr_next = paddr_reg;
      pdata_next = pdata_reg;
      err_next   = err_reg;
      case (state_reg)
         IDLE: begin
            idx_next = '0;
            if (rx_valid && rx_byte == MAGIC) begin
               state_next = ADDR;
               err_next   = 1'b0;
            end
         end
         DONE: begin
            state_next = IDLE;
            if (rx_ferr) err_next = 1'b1;
         end
         default: begin
            tmo_next = rx_valid ? '0 : tmo_reg + 32'd1;
            if (rx_ferr || tmo_hit) begin
               state_next = IDLE;
               err_next   = 1'b1;
               idx_next   = '0;
               tmo_next   = '0;
            end else if (rx_valid) begin
               idx_next   = idx_reg + 2'd1;
               field_next = field_full[31:8];
               if (idx_reg == LAST_IDX) begin
                  case (state_reg)
                     ADDR: begin
                        addr_next  = {field_full[31:2], 2'b00};
                        state_next = COUNT;
                     end
                     COUNT: begin
                        cnt_next   = field_full;
                        state_next = (field_full == 32'd0) ? DONE : DATA;
                     end
                     default: begin
                        we_next    = 1'b1;
                        paddr_next = addr_reg;
                        pdata_next = field_full;
                        addr_next  = addr_reg + 32'd4;
                        cnt_next   = cnt_reg - 32'd1;
                        if (cnt_reg == 32'd1) state_next = DONE;
                     end
                  endcase
               end
            end
         end
      endcase
   end

endmodule

// File: tb/tb_otter_prog_loader.sv
// Randomised frame-level bench for otter_prog_loader with a write scoreboard.
module tb_otter_prog_loader;
   import otter_prog_pkg::*;

   localparam int CPB = 16;
   localparam int TMO = 1000;

   typedef logic [7:0]  bq_t[$];
   typedef logic [31:0] wq_t[$];
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rx = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   wr_t  exp_q[$];
   wr_t  mon_e;

   otter_prog_loader_if pif ();

   otter_prog_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYC(TMO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rx    (rx),
      .prog  (pif)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (pif.prog_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected no write",
                     pif.prog_addr, pif.prog_data);
         end else begin
            mon_e = exp_q.pop_front();
            check("wr_addr", pif.prog_addr, mon_e.addr);
            check("wr_data", pif.prog_data, mon_e.data);
            $display("write addr 0x%08h data 0x%08h", pif.prog_addr, pif.prog_data);
         end
      end
   end

   function automatic logic [31:0] le32(input bq_t b, input int off);
      return {b[off+3], b[off+2], b[off+1], b[off]};
   endfunction

   // Reference: locate the magic byte, decode the header, list every complete word.
   task automatic model_frame(input bq_t b);
      int m = 0;
      logic [31:0] base, n;
      while (m < b.size() && b[m] != MAGIC) m++;
      if (m + 9 > b.size()) return;
      base = le32(b, m + 1) & 32'hFFFF_FFFC;
      n    = le32(b, m + 5);
      for (int i = 0; i < int'(n) && (m + 12 + 4 * i) < b.size(); i++)
         exp_q.push_back('{addr: base + 32'(4 * i), data: le32(b, m + 9 + 4 * i)});
   endtask

   function automatic bq_t build_frame(input logic [31:0] a, input wq_t words);
      bq_t q;
      logic [31:0] n = 32'(words.size());
      q.push_back(MAGIC);
      for (int k = 0; k < 4; k++) q.push_back(a[8*k +: 8]);
      for (int k = 0; k < 4; k++) q.push_back(n[8*k +: 8]);
      foreach (words[w]) for (int k = 0; k < 4; k++) q.push_back(words[w][8*k +: 8]);
      return q;
   endfunction

   task automatic send_byte(input logic [7:0] b, input logic stop_ok);
      @(negedge clk);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_ok;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      if (!stop_ok) repeat (CPB) @(negedge clk);
   endtask

   task automatic send_bytes(input bq_t q, input int from, input int upto);
      for (int i = from; i < upto; i++) begin
         send_byte(q[i], 1'b1);
         repeat ($urandom_range(0, 40)) @(negedge clk);
      end
   endtask

   task automatic settle_idle(input string tag);
      repeat (4) @(negedge clk);
      check({tag, "_busy"}, 32'(pif.busy), 32'd0);
      check({tag, "_cpu_rst"}, 32'(pif.cpu_rst), 32'd0);
      check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_we"}, 32'(pif.prog_we), 32'd0);
      check({tag, "_addr"}, pif.prog_addr, 32'd0);
      check({tag, "_data"}, pif.prog_data, 32'd0);
      check({tag, "_busy"}, 32'(pif.busy), 32'd0);
      check({tag, "_err"}, 32'(pif.err), 32'd0);
      check({tag, "_cpu_rst"}, 32'(pif.cpu_rst), 32'd1);
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: got no finish, expected finish before 900 us");
      $fatal(1, "watchdog");
   end

   initial begin
      bq_t fr, junk;
      wq_t ws;
      int  elapsed;
      logic [31:0] a;

      // Power-on reset and release.
      repeat (3) @(negedge clk);
      check_reset_values("por");
      rst_n = 1'b1;
      @(negedge clk);
      check("por_rel_cpu_rst1", 32'(pif.cpu_rst), 32'd1);
      @(negedge clk);
      check("por_rel_cpu_rst0", 32'(pif.cpu_rst), 32'd0);

      // Directed two-word frame.
      ws = '{32'h0000_0013, 32'h0010_0093};
      fr = build_frame(32'h0000_0100, ws);
      model_frame(fr);
      send_bytes(fr, 0, fr.size());
      settle_idle("dir");
      check("dir_err", 32'(pif.err), 32'd0);

      // Junk in IDLE is ignored, then a normal frame.
      junk = '{8'h11, 8'h22};
      send_bytes(junk, 0, 2);
      check("junk_busy", 32'(pif.busy), 32'd0);
      check("junk_err", 32'(pif.err), 32'd0);
      ws = '{$urandom()};
      fr = build_frame($urandom(), ws);
      model_frame(fr);
      send_bytes(fr, 0, fr.size());
      settle_idle("post_junk");

      // Zero-length frame with an unaligned address.
      ws.delete();
      fr = build_frame(32'h0000_0003, ws);
      model_frame(fr);
      send_bytes(fr, 0, 1);
      check("n0_busy_hdr", 32'(pif.busy), 32'd1);
      send_bytes(fr, 1, fr.size());
      settle_idle("n0");
      check("n0_err", 32'(pif.err), 32'd0);

      // Random frames; the first wraps the address past 0xFFFFFFFC.
      for (int f = 0; f < 4; f++) begin
         ws.delete();
         a = (f == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 3))) : $urandom();
         for (int w = 0; w < ((f == 0) ? 4 : int'($urandom_range(1, 4))); w++) ws.push_back($urandom());
         fr = build_frame(a, ws);
         model_frame(fr);
         send_bytes(fr, 0, fr.size());
         settle_idle("rand");
      end

      // Framing error during COUNT, then recovery by a new magic byte.
      ws = '{$urandom()};
      fr = build_frame($urandom(), ws);
      send_bytes(fr, 0, 5);
      send_byte(8'h01, 1'b0);
      @(negedge clk);
      check("ferr_err", 32'(pif.err), 32'd1);
      check("ferr_busy", 32'(pif.busy), 32'd0);
      model_frame(fr);
      send_bytes(fr, 0, 1);
      check("ferr_clr_err", 32'(pif.err), 32'd0);
      check("ferr_clr_busy", 32'(pif.busy), 32'd1);
      send_bytes(fr, 1, fr.size());
      settle_idle("ferr_rec");

      // Inter-byte timeout.
      junk = '{MAGIC, 8'h00};
      send_bytes(junk, 0, 2);
      elapsed = 0;
      while (pif.err !== 1'b1 && elapsed < 1200) begin
         @(negedge clk);
         elapsed++;
         if (elapsed == 900) begin
            check("tmo_early_busy", 32'(pif.busy), 32'd1);
            check("tmo_early_err", 32'(pif.err), 32'd0);
         end
      end
      check("tmo_err", 32'(pif.err), 32'd1);
      check("tmo_window", 32'(elapsed >= TMO - 2 * CPB && elapsed <= TMO), 32'd1);
      check("tmo_busy", 32'(pif.busy), 32'd0);
      check("tmo_cpu_rst_hold", 32'(pif.cpu_rst), 32'd1);
      @(negedge clk);
      check("tmo_cpu_rst_drop", 32'(pif.cpu_rst), 32'd0);

      // Reset after the first of two words.
      ws = '{$urandom(), 32'h1122_3344};
      fr = build_frame($urandom(), ws);
      junk = fr;
      junk = junk[0:12];
      model_frame(junk);
      send_bytes(fr, 0, 15);
      check("mid_first_written", 32'(exp_q.size()), 32'd0);
      rst_n = 1'b0;
      #1;
      check_reset_values("mid_rst");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_rel_cpu_rst1", 32'(pif.cpu_rst), 32'd1);
      @(negedge clk);
      check("mid_rel_cpu_rst0", 32'(pif.cpu_rst), 32'd0);
      send_bytes(fr, 15, fr.size());
      settle_idle("mid_after");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
